// File: rtl/hazard_ctrl_mc_if.sv
// Hazard-unit bundle: pipeline status in, stage-register controls out.
//   master: pipeline side, drives register numbers, stage status and cache misses.
//   slave : hazard unit, drives Stall*/Flush* controls, Forward1E/2E and MdBusy.
interface hazard_ctrl_mc_if #(
  parameter int unsigned AW = 5
);
  logic          ICacheMiss, DCacheMiss;
  logic          BranchE, JalrE, JalD;
  logic          MulDivE;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    RegReadE;
  logic          MemToRegE, RegWriteE;
  logic [2:0]    RegWriteM, RegWriteW;
  logic          StallF, FlushF, StallD, FlushD, StallE, FlushE;
  logic          StallM, FlushM, StallW, FlushW;
  logic [1:0]    Forward1E, Forward2E;
  logic          MdBusy;

  modport master (
    output ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MulDivE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadE,
           MemToRegE, RegWriteE, RegWriteM, RegWriteW,
    input  StallF, FlushF, StallD, FlushD, StallE, FlushE,
           StallM, FlushM, StallW, FlushW, Forward1E, Forward2E, MdBusy
  );

  modport slave (
    input  ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, MulDivE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadE,
           MemToRegE, RegWriteE, RegWriteM, RegWriteW,
    output StallF, FlushF, StallD, FlushD, StallE, FlushE,
           StallM, FlushM, StallW, FlushW, Forward1E, Forward2E, MdBusy
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for a 5-stage pipeline with a multi-cycle mul/div EX unit.
// Ports:
//   clk      : single clock, state on rising edge
//   CpuRst_n : asynchronous active-low reset; while low all Flush=1, Stall=0
//   hz       : hazard_ctrl_mc_if.slave bundle (status in, controls out)
// Parameters: AW register-address width, MD_LAT mul/div EX occupancy (2..15).
// Optional macro HAZARD_FORWARD_EN: enables MEM/WB forwarding into EX. When
// undefined, forwarding is tied off and RAW hazards against EX/MEM stall in ID.
// Priority: reset > cache miss > mul/div stall > branch/jalr flush > data stall > jal.
module hazard_ctrl_mc #(
  parameter int unsigned AW     = 5,
  parameter int unsigned MD_LAT = 4
) (
  input logic             clk,
  input logic             CpuRst_n,
  hazard_ctrl_mc_if.slave hz
);

  typedef enum logic [0:0] {StIdle, StMdRun} state_e;

  // First cycle is spent in StIdle, last with cnt==0, so load MD_LAT-2.
  localparam logic [3:0] CntInit = 4'(MD_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [AW-1:0] rs1d, rs2d, rde, rdm;
  logic          miss, md_stall, load_use, data_stall;
  logic [1:0]    fwd1, fwd2;

  assign rs1d = hz.Rs1D;
  assign rs2d = hz.Rs2D;
  assign rde  = hz.RdE;
  assign rdm  = hz.RdM;
  assign miss = hz.ICacheMiss | hz.DCacheMiss;

  // x0 is never a producer.
  function automatic logic rd_hit(logic [AW-1:0] rd, logic [AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

  assign load_use = hz.MemToRegE && (rd_hit(rde, rs1d) || rd_hit(rde, rs2d));

`ifdef HAZARD_FORWARD_EN
  logic [AW-1:0] rs1e, rs2e, rdw;
  assign rs1e = hz.Rs1E;
  assign rs2e = hz.Rs2E;
  assign rdw  = hz.RdW;

  assign data_stall = load_use;

  // MEM result is younger than WB, so it wins.
  always_comb begin
    fwd1 = 2'b00;
    fwd2 = 2'b00;
    if (hz.RegReadE[1] && (hz.RegWriteM != 3'b0) && rd_hit(rdm, rs1e)) begin
      fwd1 = 2'b10;
    end else if (hz.RegReadE[1] && (hz.RegWriteW != 3'b0) && rd_hit(rdw, rs1e)) begin
      fwd1 = 2'b01;
    end
    if (hz.RegReadE[0] && (hz.RegWriteM != 3'b0) && rd_hit(rdm, rs2e)) begin
      fwd2 = 2'b10;
    end else if (hz.RegReadE[0] && (hz.RegWriteW != 3'b0) && rd_hit(rdw, rs2e)) begin
      fwd2 = 2'b01;
    end
  end
`else
  // WB needs no check: the register file writes through to the ID read.
  assign data_stall = load_use
                    || (hz.RegWriteE && (rd_hit(rde, rs1d) || rd_hit(rde, rs2d)))
                    || ((hz.RegWriteM != 3'b0) && (rd_hit(rdm, rs1d) || rd_hit(rdm, rs2d)));
  assign fwd1 = 2'b00;
  assign fwd2 = 2'b00;

  logic unused_fwd;
  assign unused_fwd = ^{hz.Rs1E, hz.Rs2E, hz.RdW, hz.RegReadE, hz.RegWriteW};
`endif

  // State register.
  always_ff @(posedge clk or negedge CpuRst_n) begin
    if (!CpuRst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a cache miss freezes the FSM entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!miss) begin
      unique case (state_q)
        StIdle: begin
          if (hz.MulDivE) begin
            state_d = StMdRun;
            cnt_d   = CntInit;
          end
        end
        StMdRun: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign md_stall = !miss && (((state_q == StIdle) && hz.MulDivE) ||
                              ((state_q == StMdRun) && (cnt_q != 4'd0)));

  // Outputs.
  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.StallW    = 1'b0;
    hz.FlushF    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.Forward1E = 2'b00;
    hz.Forward2E = 2'b00;
    hz.MdBusy    = 1'b0;
    if (!CpuRst_n) begin
      hz.FlushF = 1'b1;
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushM = 1'b1;
      hz.FlushW = 1'b1;
    end else begin
      hz.Forward1E = fwd1;
      hz.Forward2E = fwd2;
      hz.MdBusy    = (state_q == StMdRun);
      if (miss) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.StallW = 1'b1;
      end else if (md_stall) begin
        // Hold F/D/E and feed a bubble into MEM while the unit iterates.
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else if (hz.BranchE || hz.JalrE) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (data_stall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (hz.JalD) begin
        hz.FlushD = 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_ctrl_mc.md
HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter MD_LAT, default 4, multi-cycle EX occupancy in cycles; legal range 2..15.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 CpuRst_n  in  1  reset, asynchronous, active-low.
REQ-005 ICacheMiss, DCacheMiss  in  1 each  cache miss pending.
REQ-006 BranchE, JalrE, JalD  in  1 each  taken branch in EX / jalr in EX / jal in ID.
REQ-007 MulDivE  in  1  EX holds a multi-cycle mul/div instruction.
REQ-008 Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  AW each  source/destination register numbers.
REQ-009 RegReadE  in  2  bit1: rs1 used in EX; bit0: rs2 used in EX.
REQ-010 MemToRegE, RegWriteE  in  1 each  EX is a load / EX writes Rd.
REQ-011 RegWriteM, RegWriteW  in  3 each  nonzero = stage writes Rd.
REQ-012 StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1 each  stage-register hold/clear.
REQ-013 Forward1E, Forward2E  out  2 each  00 regfile, 01 from WB, 10 from MEM.
REQ-014 MdBusy  out  1  high while FSM is in MD_RUN.

Function
REQ-015 Register x0 never matches; any comparison with Rd==0 is false.
REQ-016 Forward1E = 10 if RegReadE[1], RegWriteM!=0, RdM==Rs1E; else 01 if RegReadE[1], RegWriteW!=0, RdW==Rs1E; else 00 (MEM beats WB).
REQ-017 Forward2E identical using RegReadE[0] and Rs2E.
REQ-018 Load-use: MemToRegE and RdE in {Rs1D,Rs2D} -> StallF, StallD, FlushE for that cycle.
REQ-019 BranchE or JalrE -> FlushD, FlushE; load-use stall suppressed in that cycle.
REQ-020 JalD -> FlushD, unless StallD is asserted in the same cycle.
REQ-021 FSM states IDLE, MD_RUN; 4-bit counter cnt.
REQ-022 IDLE and MulDivE and no miss: assert StallF/D/E and FlushM; cnt<=MD_LAT-2; next MD_RUN.
REQ-023 MD_RUN, cnt!=0: assert StallF/D/E and FlushM; cnt<=cnt-1.
REQ-024 MD_RUN, cnt==0: no MD stall; next IDLE; EX instruction advances, giving MD_LAT total EX cycles.
REQ-025 Any cache miss: all five Stall outputs 1, all Flush outputs 0, FSM state and cnt frozen.
REQ-026 Priority: reset > cache miss > MD stall > branch/jalr flush > load-use > JalD.
REQ-027 FlushF is 0 outside reset; outputs are combinational from inputs and FSM state.

Reset
REQ-028 CpuRst_n low asynchronously forces IDLE, cnt=0.
REQ-029 While CpuRst_n low: all Flush outputs 1, all Stall outputs 0, Forward1E/2E=00, MdBusy=0.
REQ-030 Reset during MD_RUN aborts the operation; first cycle after release is IDLE.

Configuration
REQ-031 Macro HAZARD_FORWARD_EN defined: forwarding per REQ-016/017.
REQ-032 Macro undefined: Forward1E/2E tied 00; any Rs1D/Rs2D equal to RdE (RegWriteE) or RdM (RegWriteM!=0) -> StallF, StallD, FlushE; WB not compared (regfile writes through).

Verification
REQ-033 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, RegReadE=10 -> Forward1E=10, Forward2E=00.
REQ-034 MemToRegE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 one cycle; with BranchE=1 also -> FlushD=FlushE=1, StallD=0.
REQ-035 MD_LAT=4, MulDivE=1 at cycle 0 -> StallE=1 cycles 0-2, 0 at cycle 3; MdBusy=1 cycles 1-3.
REQ-036 DCacheMiss=1 for 3 cycles during MD_RUN cnt=1 -> all Stall=1, cnt stays 1; release completes after 2 more cycles.
REQ-037 CpuRst_n low mid-MD_RUN -> all Flush=1 immediately, MdBusy=0; MulDivE=0 after release -> no stall.
REQ-038 HAZARD_FORWARD_EN undefined, RegWriteE=1, RdE=3, Rs1D=3 -> StallF=StallD=FlushE=1, Forward1E=00.
